imem_loader: RTL and testbench
==============================

# imem_loader

Byte-stream writer for the instruction memory: accepts a program image over a valid/ready byte interface, writes it big-endian into the byte-addressed instruction memory, and checks an XOR checksum trailer. Sits beside the fetch stage as the write-side counterpart to the PC-driven read port. While loading, it stalls the pipeline (PC and IF/ID enables) and on success pulses a CPU reset request so fetch restarts cleanly.

## Interface
- ADDR_WIDTH, 8, instruction-memory byte address width.
- RELEASE_CYCLES, 3, cycles `cpu_reset_req` is held after a good load (≥1).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle load request, sampled in IDLE or ERROR only.
- start_address  in  ADDR_WIDTH  first byte address, latched on start.
- word_count  in  ADDR_WIDTH-1  number of 32-bit words, latched on start.
- byte_in  in  8  stream byte.
- byte_valid  in  1  `byte_in` valid.
- byte_ready  out  1  loader can accept a byte.
- mem_write_enable  out  1  instruction-memory byte write strobe.
- mem_address  out  ADDR_WIDTH  write address.
- mem_data  out  8  write data.
- cpu_hold  out  1  drives PC_enable / IF_ID_Enable low when 1.
- cpu_reset_req  out  1  CPU pipeline reset request.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky until next accepted start.

## Operation
- States: IDLE, LOAD, CHECK, RELEASE, ERROR.
- IDLE: `cpu_hold`=0, `byte_ready`=0. On `start`:
  - `start_address[1:0]`≠0 or `word_count` > 2^(ADDR_WIDTH-2) → ERROR.
  - `word_count`=0 → CHECK.
  - otherwise → LOAD.
- LOAD: `byte_ready`=1, `cpu_hold`=1.
  - Each handshake (`byte_valid && byte_ready` at a rising edge) writes the byte to the current address, XORs it into the running checksum (cleared on start), then increments the address modulo 2^ADDR_WIDTH. Wrap past the top address is legal.
  - Byte order: first byte of each word goes to the lowest address (big-endian, matching fetch).
  - After 4×`word_count` bytes → CHECK.
- CHECK: `byte_ready`=1, `cpu_hold`=1. The next accepted byte is compared with the checksum; it is not written to memory.
  - Equal → RELEASE.
  - Unequal → ERROR.
- RELEASE: `cpu_hold`=1, `cpu_reset_req`=1 for RELEASE_CYCLES cycles. Then go to IDLE, with `done` pulsing in the first IDLE cycle.
- ERROR: `error`=1, `cpu_hold`=1, `byte_ready`=0. Only `start` exits, with the same checks as IDLE; `error` clears on that edge.
- `start` in LOAD, CHECK or RELEASE is ignored. `byte_valid` while `byte_ready`=0 is ignored (no write, no checksum update).

## Timing
- Reset values: `byte_ready`=0, `mem_write_enable`=0, `mem_address`=0, `mem_data`=0, `cpu_hold`=0, `cpu_reset_req`=0, `done`=0, `error`=0, state IDLE, counters 0.
- All outputs are registered.
- A byte accepted at edge N appears on `mem_write_enable`/`mem_address`/`mem_data` during cycle N+1, and memory captures it at edge N+1. Throughput is 1 byte/cycle.
- `cpu_hold` rises the cycle after `start` is accepted. It falls in the first IDLE cycle after RELEASE, the same cycle as `done`.
- `byte_ready` drops the cycle after the checksum byte is accepted.
- Reset asserted mid-load: all outputs return to reset values immediately, without waiting for a clock edge. The partially written image is not repaired.

## Structure
- Shared package holds:
  - state encoding enum (IDLE/LOAD/CHECK/RELEASE/ERROR);
  - constant `BYTES_PER_WORD`=4.
- One sub-module, `imem_byte_counter`: loadable address/byte counter with modulo wrap and terminal-count flag.
- FSM, checksum and output registers live in `imem_loader`.

## Test plan
- Normal load: start_address=0x00, word_count=2, bytes E2 11 00 00 E0 80 51 83, checksum 0x41.
  - Writes at 0x00–0x07 with those values.
  - `cpu_hold` high throughout.
  - `cpu_reset_req` high for 3 cycles, then `done` pulses.
  - Fetch at PC 0 returns 0xE2110000 (ANDS); fetch at PC 4 returns 0xE0805183 (ADD).
- Bad checksum: same image, trailer 0x40.
  - 8 writes occur; ERROR is entered; `error`=1 and `cpu_hold`=1 persist.
  - `done` never pulses.
  - A new `start` clears `error`.
- Wrap-around: start_address=0xFC, word_count=2 → writes at 0xFC–0xFF, then 0x00–0x03.
- Range/alignment: word_count=65 → ERROR the cycle after start, no writes. Same for start_address=0x02.
- Backpressure and ignored start: `byte_valid` toggled every other cycle, plus `start` pulsed in LOAD.
  - Exactly 4×`word_count` writes occur, with no duplicates or skips.
  - The `start` pulse has no effect.
- Reset mid-load: assert reset after byte 3.
  - All outputs go to reset values without a clock edge.
  - After release, the block is in IDLE and `byte_ready`=0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding, constants and checksum helper for
// the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CHECK   = 3'd2,
    RELEASE = 3'd3,
    ERROR   = 3'd4
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;

  // Running XOR checksum over the image bytes.
  function automatic logic [7:0] checksum_update(input logic [7:0] acc,
                                                 input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write port of the
// loader. The master side feeds bytes and receives memory writes.
interface imem_loader_if #(parameter int ADDR_WIDTH = 8);

  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  mem_write_enable;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [7:0]            mem_data;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, mem_write_enable, mem_address, mem_data
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, mem_write_enable, mem_address, mem_data
  );

endinterface

// File: rtl/imem_byte_counter.sv
// imem_byte_counter: write-address counter that wraps modulo 2^ADDR_WIDTH,
// paired with a remaining-byte down counter whose terminal flag marks the
// last image byte.
module imem_byte_counter #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_address,
  input  logic [ADDR_WIDTH:0]   load_bytes,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   BYTES_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] address_r;
  logic [ADDR_WIDTH:0]   remaining_r;

  // Load on start, advance address and consume one byte on every step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      address_r   <= {ADDR_WIDTH{1'b0}};
      remaining_r <= {(ADDR_WIDTH+1){1'b0}};
    end else if (load) begin
      address_r   <= load_address;
      remaining_r <= load_bytes;
    end else if (step) begin
      address_r   <= address_r + ADDR_ONE;
      remaining_r <= remaining_r - BYTES_ONE;
    end else begin
      address_r   <= address_r;
      remaining_r <= remaining_r;
    end
  end

  assign address = address_r;
  assign last    = (remaining_r == BYTES_ONE);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: writes a big-endian program image from a byte stream into the
// instruction memory, verifies an XOR checksum trailer, holds the pipeline
// while loading and requests a CPU reset after a good load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int RELEASE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_address,
  input  logic [ADDR_WIDTH-2:0] word_count,
  imem_loader_if.slave          bus,
  output logic                  cpu_hold,
  output logic                  cpu_reset_req,
  output logic                  done,
  output logic                  error
);

  localparam int BYTE_SHIFT    = $clog2(BYTES_PER_WORD);
  localparam int MAX_WORDS_INT = 1 << (ADDR_WIDTH - 2);
  localparam logic [ADDR_WIDTH-2:0] MAX_WORDS  = MAX_WORDS_INT[ADDR_WIDTH-2:0];
  localparam logic [ADDR_WIDTH-2:0] WORDS_ZERO = {(ADDR_WIDTH-1){1'b0}};
  localparam int REL_W         = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam int REL_LAST_INT  = RELEASE_CYCLES - 1;
  localparam logic [REL_W-1:0] REL_LAST = REL_LAST_INT[REL_W-1:0];
  localparam logic [REL_W-1:0] REL_ZERO = {REL_W{1'b0}};
  localparam logic [REL_W-1:0] REL_ONE  = {{(REL_W-1){1'b0}}, 1'b1};

  loader_state_t         state_r;
  logic [7:0]            checksum_r;
  logic [REL_W-1:0]      release_cnt_r;
  logic                  byte_ready_r;
  logic                  mem_write_enable_r;
  logic [ADDR_WIDTH-1:0] mem_address_r;
  logic [7:0]            mem_data_r;
  logic                  cpu_hold_r;
  logic                  cpu_reset_req_r;
  logic                  done_r;
  logic                  error_r;

  logic                  start_take_s;
  logic                  start_bad_s;
  logic                  accept_s;
  logic                  step_s;
  logic [ADDR_WIDTH:0]   total_bytes_s;
  logic [ADDR_WIDTH-1:0] cnt_address_s;
  logic                  cnt_last_s;

  assign total_bytes_s = {word_count, {BYTE_SHIFT{1'b0}}};

  // Decode start acceptance, start legality and the stream handshake.
  always_comb begin
    start_take_s = 1'b0;
    start_bad_s  = 1'b0;
    accept_s     = 1'b0;
    step_s       = 1'b0;
    if (state_r == IDLE || state_r == ERROR) begin
      start_take_s = start;
    end else begin
      start_take_s = 1'b0;
    end
    if (start_address[1:0] != 2'b00 || word_count > MAX_WORDS) begin
      start_bad_s = 1'b1;
    end else begin
      start_bad_s = 1'b0;
    end
    accept_s = bus.byte_valid & byte_ready_r;
    if (state_r == LOAD) begin
      step_s = accept_s;
    end else begin
      step_s = 1'b0;
    end
  end

  imem_byte_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_counter (
    .clk          (clk),
    .reset        (reset),
    .load         (start_take_s),
    .load_address (start_address),
    .load_bytes   (total_bytes_s),
    .step         (step_s),
    .address      (cnt_address_s),
    .last         (cnt_last_s)
  );

  // Loader FSM with checksum accumulation and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r            <= IDLE;
      checksum_r         <= 8'h00;
      release_cnt_r      <= REL_ZERO;
      byte_ready_r       <= 1'b0;
      mem_write_enable_r <= 1'b0;
      mem_address_r      <= {ADDR_WIDTH{1'b0}};
      mem_data_r         <= 8'h00;
      cpu_hold_r         <= 1'b0;
      cpu_reset_req_r    <= 1'b0;
      done_r             <= 1'b0;
      error_r            <= 1'b0;
    end else begin
      mem_write_enable_r <= 1'b0;
      done_r             <= 1'b0;
      case (state_r)
        IDLE, ERROR: begin
          if (start_take_s) begin
            checksum_r    <= 8'h00;
            release_cnt_r <= REL_ZERO;
            error_r       <= start_bad_s;
            cpu_hold_r    <= 1'b1;
            if (start_bad_s) begin
              state_r      <= ERROR;
              byte_ready_r <= 1'b0;
            end else if (word_count == WORDS_ZERO) begin
              state_r      <= CHECK;
              byte_ready_r <= 1'b1;
            end else begin
              state_r      <= LOAD;
              byte_ready_r <= 1'b1;
            end
          end else begin
            state_r <= state_r;
          end
        end
        LOAD: begin
          if (accept_s) begin
            mem_write_enable_r <= 1'b1;
            mem_address_r      <= cnt_address_s;
            mem_data_r         <= bus.byte_in;
            checksum_r         <= checksum_update(checksum_r, bus.byte_in);
            if (cnt_last_s) begin
              state_r <= CHECK;
            end else begin
              state_r <= LOAD;
            end
          end else begin
            state_r <= LOAD;
          end
        end
        CHECK: begin
          // The trailer byte is compared only; it never reaches memory.
          if (accept_s) begin
            byte_ready_r <= 1'b0;
            if (bus.byte_in == checksum_r) begin
              state_r         <= RELEASE;
              cpu_reset_req_r <= 1'b1;
              release_cnt_r   <= REL_ZERO;
            end else begin
              state_r <= ERROR;
              error_r <= 1'b1;
            end
          end else begin
            state_r <= CHECK;
          end
        end
        RELEASE: begin
          if (release_cnt_r == REL_LAST) begin
            state_r         <= IDLE;
            cpu_reset_req_r <= 1'b0;
            cpu_hold_r      <= 1'b0;
            done_r          <= 1'b1;
          end else begin
            release_cnt_r <= release_cnt_r + REL_ONE;
          end
        end
        default: begin
          state_r         <= IDLE;
          byte_ready_r    <= 1'b0;
          cpu_hold_r      <= 1'b0;
          cpu_reset_req_r <= 1'b0;
          error_r         <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready       = byte_ready_r;
  assign bus.mem_write_enable = mem_write_enable_r;
  assign bus.mem_address      = mem_address_r;
  assign bus.mem_data         = mem_data_r;
  assign cpu_hold             = cpu_hold_r;
  assign cpu_reset_req        = cpu_reset_req_r;
  assign done                 = done_r;
  assign error                = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader. Expected memory
// writes are queued when a load is issued; a negedge monitor pops and compares
// every write the DUT presents.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AW = 8;
  localparam int RC = 3;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] start_address;
  logic [6:0] word_count;
  logic       cpu_hold;
  logic       cpu_reset_req;
  logic       done;
  logic       error;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW), .RELEASE_CYCLES(RC)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .start_address (start_address),
    .word_count    (word_count),
    .bus           (bus),
    .cpu_hold      (cpu_hold),
    .cpu_reset_req (cpu_reset_req),
    .done          (done),
    .error         (error)
  );

  int checks = 0;
  int errors = 0;
  int wr_total = 0;
  int rr_total = 0;
  int done_total = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  img[$];
  logic [7:0]  tbmem[256];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Instruction memory model: captures writes at the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      if (bus.mem_write_enable === 1'b1) tbmem[bus.mem_address] = bus.mem_data;
    end
  end

  // Monitor: counts pulses and checks every write against the scoreboard.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (cpu_reset_req === 1'b1) rr_total++;
      if (done === 1'b1) done_total++;
      if (bus.mem_write_enable === 1'b1) begin
        wr_total++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   bus.mem_address, bus.mem_data);
        end else begin
          e = exp_q.pop_front();
          chk_int("write_addr", int'(bus.mem_address), int'(e[15:8]));
          chk_int("write_data", int'(bus.mem_data), int'(e[7:0]));
        end
      end
    end
  end

  function automatic logic [7:0] img_sum();
    logic [7:0] s;
    s = 8'h00;
    foreach (img[i]) s = s ^ img[i];
    return s;
  endfunction

  task automatic fill_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic word_at(input logic [7:0] a, output logic [31:0] w);
    logic [7:0] b1, b2, b3;
    b1 = a + 8'd1;
    b2 = a + 8'd2;
    b3 = a + 8'd3;
    w = {tbmem[a], tbmem[b1], tbmem[b2], tbmem[b3]};
  endtask

  task automatic send_byte(input logic [7:0] b, input bit is_data, output bit ok);
    int   budget;
    logic rdy;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    budget         = 0;
    do begin
      rdy = bus.byte_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (rdy !== 1'b1 && budget < 20);
    bus.byte_valid = 1'b0;
    ok = (rdy === 1'b1);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: byte_ready stayed 0 for 20 cycles, expected 1");
    end else begin
      chk_bit("write_strobe_latency", bus.mem_write_enable, logic'(is_data));
      chk_bit("hold_during_load", cpu_hold, 1'b1);
    end
  endtask

  // Issue one load of img with the given trailer and check its outcome.
  task automatic run_load(input logic [7:0] sa, input logic [6:0] wc, input logic [7:0] trailer,
                          input bit gap, input bit poke_start);
    int         n, wr_base, rr_base, done_base;
    bit         bad, good_sum, ok, found;
    logic [7:0] a;
    n        = int'(wc) * BYTES_PER_WORD;
    bad      = (sa[1:0] != 2'b00) || (wc > 7'd64);
    good_sum = (trailer == img_sum());
    wr_base   = wr_total;
    rr_base   = rr_total;
    done_base = done_total;
    if (!bad) begin
      for (int i = 0; i < n; i++) begin
        a = sa + 8'(i);
        exp_q.push_back({a, img[i]});
      end
    end
    start_address = sa;
    word_count    = wc;
    start         = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk_bit("error_after_start", error, logic'(bad));
    chk_bit("hold_after_start", cpu_hold, 1'b1);
    if (bad) begin
      chk_bit("ready_in_error", bus.byte_ready, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      chk_int("no_writes_on_reject", wr_total - wr_base, 0);
      chk_bit("error_sticky", error, 1'b1);
      return;
    end
    for (int i = 0; i < n; i++) begin
      send_byte(img[i], 1'b1, ok);
      if (!ok) begin exp_q.delete(); return; end
      if (poke_start && i == 2) begin
        start_address = 8'h81;
        word_count    = 7'd1;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end else if (gap) begin
        @(posedge clk);
        #1;
      end
    end
    send_byte(trailer, 1'b0, ok);
    if (!ok) begin exp_q.delete(); return; end
    chk_bit("ready_drops_after_trailer", bus.byte_ready, 1'b0);
    if (good_sum) begin
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
        if (done === 1'b1) found = 1'b1;
        else begin @(posedge clk); #1; end
      end
      if (!found) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: done stayed 0 for 20 cycles, expected a pulse");
      end else begin
        chk_bit("hold_falls_with_done", cpu_hold, 1'b0);
        chk_int("reset_req_cycles", rr_total - rr_base, RC);
        @(posedge clk);
        #1;
        chk_bit("done_one_cycle", done, 1'b0);
        chk_bit("reset_req_low_after", cpu_reset_req, 1'b0);
      end
    end else begin
      repeat (3) begin @(posedge clk); #1; end
      chk_bit("error_on_bad_sum", error, 1'b1);
      chk_bit("hold_in_error", cpu_hold, 1'b1);
      chk_bit("ready_in_error", bus.byte_ready, 1'b0);
      chk_int("no_done_on_bad_sum", done_total - done_base, 0);
    end
    chk_int("write_count", wr_total - wr_base, n);
    chk_int("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  sa, tr;
    logic [6:0]  wc;
    bit          ok;
    int          wr_base;
    reset          = 1'b0;
    start          = 1'b0;
    start_address  = 8'h00;
    word_count     = 7'd0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    #1;
    chk_bit("rst_byte_ready", bus.byte_ready, 1'b0);
    chk_bit("rst_mem_we", bus.mem_write_enable, 1'b0);
    chk_int("rst_mem_address", int'(bus.mem_address), 0);
    chk_int("rst_mem_data", int'(bus.mem_data), 0);
    chk_bit("rst_cpu_hold", cpu_hold, 1'b0);
    chk_bit("rst_cpu_reset_req", cpu_reset_req, 1'b0);
    chk_bit("rst_done", done, 1'b0);
    chk_bit("rst_error", error, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Normal load of two instructions.
    img = '{8'hE2, 8'h11, 8'h00, 8'h00, 8'hE0, 8'h80, 8'h51, 8'h83};
    run_load(8'h00, 7'd2, 8'h41, 1'b0, 1'b0);
    word_at(8'h00, w);
    chk_int("fetch_pc0", int'(w), int'(32'hE2110000));
    word_at(8'h04, w);
    chk_int("fetch_pc4", int'(w), int'(32'hE0805183));

    // Bad checksum, then a zero-word load whose start must clear error.
    run_load(8'h00, 7'd2, 8'h40, 1'b0, 1'b0);
    img.delete();
    run_load(8'h40, 7'd0, 8'h00, 1'b0, 1'b0);

    // Range and alignment rejects.
    run_load(8'h00, 7'd65, 8'h00, 1'b0, 1'b0);
    fill_img(8);
    run_load(8'h02, 7'd2, img_sum(), 1'b0, 1'b0);

    // Largest legal image fills the whole memory.
    fill_img(256);
    run_load(8'h80, 7'd64, img_sum(), 1'b0, 1'b0);

    // Backpressure with a start pulse during LOAD.
    fill_img(12);
    run_load(8'h10, 7'd3, img_sum(), 1'b1, 1'b1);

    // Reset after the third byte.
    fill_img(8);
    wr_base = wr_total;
    for (int i = 0; i < 8; i++) exp_q.push_back({8'(8'h20 + 8'(i)), img[i]});
    start_address = 8'h20;
    word_count    = 7'd2;
    start         = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(img[i], 1'b1, ok);
    @(posedge clk);
    #1;
    chk_int("writes_before_reset", wr_total - wr_base, 3);
    reset = 1'b0;
    #1;
    chk_bit("mid_rst_byte_ready", bus.byte_ready, 1'b0);
    chk_bit("mid_rst_mem_we", bus.mem_write_enable, 1'b0);
    chk_int("mid_rst_mem_address", int'(bus.mem_address), 0);
    chk_int("mid_rst_mem_data", int'(bus.mem_data), 0);
    chk_bit("mid_rst_cpu_hold", cpu_hold, 1'b0);
    chk_bit("mid_rst_reset_req", cpu_reset_req, 1'b0);
    chk_bit("mid_rst_error", error, 1'b0);
    exp_q.delete();
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_bit("post_rst_byte_ready", bus.byte_ready, 1'b0);
    chk_bit("post_rst_cpu_hold", cpu_hold, 1'b0);

    // Wrap-around past the top address.
    fill_img(8);
    run_load(8'hFC, 7'd2, img_sum(), 1'b0, 1'b0);

    // Randomized loads.
    for (int r = 0; r < 8; r++) begin
      sa = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) sa[1:0] = 2'b00;
      wc = 7'($urandom_range(0, 68));
      fill_img(int'(wc) * BYTES_PER_WORD);
      tr = img_sum();
      if ($urandom_range(0, 3) == 0) tr = tr ^ 8'($urandom_range(1, 255));
      run_load(sa, wc, tr, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
